aes_key_expand_seq: RTL

- Sequential AES key-schedule engine; sits directly upstream of the cipher and inverse-cipher datapaths and supplies their round keys.
- Accepts one 128/192/256-bit cipher key and generates one 32-bit schedule word per clock into an internal 60-word buffer.
- Consumers then read any 128-bit round key by index, combinationally.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_subword.sv | 14 +
 rtl/aes_key_expand_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, round-key word type and byte helpers
// used by the key schedule and the cipher datapaths.
package aes_pkg;

    localparam logic [3:0] NK128 = 4'd4;
    localparam logic [3:0] NK192 = 4'd6;
    localparam logic [3:0] NK256 = 4'd8;

    localparam logic [3:0] NR10 = 4'd10;
    localparam logic [3:0] NR12 = 4'd12;
    localparam logic [3:0] NR14 = 4'd14;

    typedef logic [31:0] rk_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_e;

    // Forward S-box, entry 0x00 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_for(input logic [3:0] n);
        case (n)
            NK192:   return NR12;
            NK256:   return NR14;
            default: return NR10;
        endcase
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        dout = {sbox(din[31:24]), sbox(din[23:16]),
                sbox(din[15:8]),  sbox(din[7:0])};
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per clock into a
// 60-word buffer, round keys read back combinationally by index.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_WORDS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [3:0]   nk,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic [3:0]   nr,
    output logic         busy,
    output logic         key_valid,
    output logic         done,
    output logic         err
);

    ks_state_e  state_q, state_d;
    logic [3:0] nk_q, nk_d;
    logic [3:0] nr_q, nr_d;
    logic [5:0] i_q, i_d;
    logic [2:0] j_q, j_d;
    logic [7:0] rcon_q, rcon_d;
    logic       busy_q, busy_d;
    logic       kv_q, kv_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    rk_word_t   w_q [MAX_WORDS];

    logic       nk_ok;
    logic       load;
    logic       wr_en;
    logic [5:0] prev_idx;
    logic [5:0] back_idx;
    logic [5:0] last_i;
    logic [255:0] key_al;
    rk_word_t   w_prev, w_back;
    rk_word_t   sub_in, sub_out;
    rk_word_t   temp, w_new;
    logic [3:0] rd_idx;
    logic [5:0] rd_base;

    assign nk_ok = (nk == NK128) || (nk == NK192) || (nk == NK256);

    // Left-justify the used key field so word k sits at a fixed slot
    assign key_al = key << (9'd256 - {nk, 5'd0});

    assign prev_idx = (i_q == 6'd0) ? 6'd0 : i_q - 6'd1;
    assign back_idx = i_q - {2'b00, nk_q};
    assign last_i   = {nr_q, 2'b11};
    assign w_prev   = w_q[prev_idx];
    assign w_back   = w_q[back_idx];

    assign sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]}
                                  : w_prev;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        temp = w_prev;
        if (j_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == NK256 && j_q == 3'd4) begin
            temp = sub_out;
        end
        w_new = w_back ^ temp;
    end

    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        kv_d    = kv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && nk_ok) begin
                    load    = 1'b1;
                    nk_d    = nk;
                    nr_d    = nr_for(nk);
                    i_d     = {2'b00, nk};
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_EXPAND;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_EXPAND: begin
                wr_en = 1'b1;
                i_d   = i_q + 6'd1;
                j_d   = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0
                                                     : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_i) begin
                    busy_d  = 1'b0;
                    kv_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Slots nk..7 receive filler here; expansion rewrites them first
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load) begin
                for (int k = 0; k < 8; k++) begin
                    w_q[k] <= key_al[255-32*k -: 32];
                end
            end else if (wr_en) begin
                w_q[i_q] <= w_new;
            end
        end
    end

    assign rd_idx  = (rk_idx > NR14) ? NR14 : rk_idx;
    assign rd_base = {rd_idx, 2'b00};

    always_comb begin
        rk_out = '0;
        if (kv_q && rk_idx <= nr_q) begin
            rk_out = {w_q[rd_base],        w_q[rd_base + 6'd1],
                      w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

    assign nr        = nr_q;
    assign busy      = busy_q;
    assign key_valid = kv_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
